// File: rtl/vco_phase_decoder_if.sv
// Decimated-sample output channel of the VCO ADC back end (valid/ready).
interface vco_phase_decoder_if #(
    parameter int OUT_WIDTH = 20
);
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/vco_phase_decoder.sv
// VCO-based ADC back end: first-differences the VCO phase word (modulo
// 2^PHASE_WIDTH), integrates-and-dumps over 2^OSR_LOG2 samples and presents
// each decimated sample on a single-entry valid/ready output register.
module vco_phase_decoder #(
    parameter int PHASE_WIDTH = 11,
    parameter int OSR_LOG2    = 9,
    parameter int OUT_WIDTH   = PHASE_WIDTH + OSR_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   vco_enb,
    input  logic [PHASE_WIDTH-1:0] p_in,
    output logic                   overrun,
    vco_phase_decoder_if.master    out_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;

    state_t                 state_q, state_d;
    logic                   vco_enb_q, vco_enb_d;
    logic [PHASE_WIDTH-1:0] p_prev_q, p_prev_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [OSR_LOG2-1:0]    cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   dout_q, dout_d;
    logic                   dvld_q, dvld_d;
    logic                   ovr_q, ovr_d;

    logic [PHASE_WIDTH-1:0] delta;
    logic [OUT_WIDTH-1:0]   sum;
    logic                   new_result;
    logic                   handshake;

    // Unsigned modular difference: a phase wrap past 2^PHASE_WIDTH-1 still
    // yields the true (small, positive) frequency count.
    function automatic logic [PHASE_WIDTH-1:0] phase_delta(
        input logic [PHASE_WIDTH-1:0] cur,
        input logic [PHASE_WIDTH-1:0] prev
    );
        return cur - prev;
    endfunction

    assign delta     = phase_delta(p_in, p_prev_q);
    assign sum       = acc_q + {{(OUT_WIDTH-PHASE_WIDTH){1'b0}}, delta};
    assign handshake = dvld_q & out_if.data_ready;

    // Next-state logic: conversion FSM, integrate-and-dump, output register.
    always_comb begin
        state_d    = state_q;
        vco_enb_d  = vco_enb_q;
        p_prev_d   = p_prev_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dvld_d     = dvld_q;
        ovr_d      = ovr_q;
        new_result = 1'b0;

        case (state_q)
            IDLE: begin
                vco_enb_d = 1'b1;
                if (en) begin
                    state_d   = PRIME;
                    vco_enb_d = 1'b0;
                    ovr_d     = 1'b0;
                end
            end
            PRIME: begin
                acc_d = '0;
                cnt_d = '0;
                if (!en) begin
                    state_d   = IDLE;
                    vco_enb_d = 1'b1;
                end else begin
                    p_prev_d = p_in;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (!en) begin
                    // Abandon the partial block; a pending output is kept.
                    state_d   = IDLE;
                    vco_enb_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    p_prev_d = p_in;
                    if (cnt_q == CNT_LAST) begin
                        new_result = 1'b1;
                        acc_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                vco_enb_d = 1'b1;
            end
        endcase

        // Single-entry output buffer: a new result is only accepted if the
        // slot is free or is being drained on this same edge.
        if (new_result) begin
            if (!dvld_q || handshake) begin
                dout_d = sum;
                dvld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (handshake) begin
            dvld_d = 1'b0;
        end
    end

    // State and datapath registers, all cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vco_enb_q <= 1'b1;
            p_prev_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            dvld_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vco_enb_q <= vco_enb_d;
            p_prev_q  <= p_prev_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            dvld_q    <= dvld_d;
            ovr_q     <= ovr_d;
        end
    end

    assign vco_enb           = vco_enb_q;
    assign overrun           = ovr_q;
    assign out_if.data_out   = dout_q;
    assign out_if.data_valid = dvld_q;

endmodule

// File: tb/tb_vco_phase_decoder.sv
// Directed bench for vco_phase_decoder: one instance at default parameters
// (OSR=512) and one with OSR_LOG2=2 (OSR=4) for the detailed scenarios.
module tb_vco_phase_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic        vco_enb_a, vco_enb_b;
    logic        overrun_a, overrun_b;
    logic [10:0] p_a, p_b;

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    vco_phase_decoder_if #(.OUT_WIDTH(20)) if_a ();
    vco_phase_decoder_if #(.OUT_WIDTH(13)) if_b ();

    vco_phase_decoder #(
        .PHASE_WIDTH(11),
        .OSR_LOG2   (9)
    ) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en_a),
        .vco_enb(vco_enb_a),
        .p_in   (p_a),
        .overrun(overrun_a),
        .out_if (if_a.master)
    );

    vco_phase_decoder #(
        .PHASE_WIDTH(11),
        .OSR_LOG2   (2)
    ) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en_b),
        .vco_enb(vco_enb_b),
        .p_in   (p_b),
        .overrun(overrun_b),
        .out_if (if_b.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_b(input logic [10:0] p);
        p_b = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] pv;
        int          s;

        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        p_a   = '0;
        p_b   = '0;
        if_a.data_ready = 1'b1;
        if_b.data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_vco_enb",  {31'd0, vco_enb_b}, 32'd1);
        chk("rst_valid",    {31'd0, if_b.data_valid}, 32'd0);
        chk("rst_data_out", {19'd0, if_b.data_out}, 32'd0);
        chk("rst_overrun",  {31'd0, overrun_b}, 32'd0);
        chk("rst_valid_a",  {31'd0, if_a.data_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: default OSR=512, phase ramps by 3 per cycle
        en_a = 1'b1;
        p_a  = '0;
        for (int n = 0; n <= 1026; n++) begin
            @(posedge clk);
            #1;
            p_a = p_a + 11'd3;
            if (n == 0)    chk("t1_vco_enb_on", {31'd0, vco_enb_a}, 32'd0);
            if (n == 512)  chk("t1_valid_early", {31'd0, if_a.data_valid}, 32'd0);
            if (n == 513) begin
                chk("t1_valid_first", {31'd0, if_a.data_valid}, 32'd1);
                chk("t1_data_first",  {12'd0, if_a.data_out}, 32'd1536);
            end
            if (n == 514)  chk("t1_valid_pulse", {31'd0, if_a.data_valid}, 32'd0);
            if (n == 1025) begin
                chk("t1_valid_second", {31'd0, if_a.data_valid}, 32'd1);
                chk("t1_data_second",  {12'd0, if_a.data_out}, 32'd1536);
            end
        end
        en_a = 1'b0;

        // Test 2: phase wraps past 2047 with step 5
        en_b = 1'b1;
        step_b(11'd2040);  // E0: IDLE -> PRIME
        step_b(11'd2040);  // E1: PRIME captures
        step_b(11'd2045);
        step_b(11'd2);
        step_b(11'd7);
        chk("t2_valid_early", {31'd0, if_b.data_valid}, 32'd0);
        step_b(11'd12);    // E5
        chk("t2_valid", {31'd0, if_b.data_valid}, 32'd1);
        chk("t2_data_wrap", {19'd0, if_b.data_out}, 32'd20);
        step_b(11'd17);
        chk("t2_valid_drop", {31'd0, if_b.data_valid}, 32'd0);
        en_b = 1'b0;
        step_b(11'd17);
        chk("t2_vco_enb_off", {31'd0, vco_enb_b}, 32'd1);

        // Test 3: stalled VCO, constant phase
        en_b = 1'b1;
        step_b(11'd100);   // E0
        chk("t3_vco_enb_on", {31'd0, vco_enb_b}, 32'd0);
        repeat (4) step_b(11'd100);
        step_b(11'd100);   // E5
        chk("t3_valid1", {31'd0, if_b.data_valid}, 32'd1);
        chk("t3_data1",  {19'd0, if_b.data_out}, 32'd0);
        step_b(11'd100);
        chk("t3_valid_gap", {31'd0, if_b.data_valid}, 32'd0);
        repeat (2) step_b(11'd100);
        step_b(11'd100);   // E9
        chk("t3_valid2", {31'd0, if_b.data_valid}, 32'd1);
        chk("t3_data2",  {19'd0, if_b.data_out}, 32'd0);
        en_b = 1'b0;
        step_b(11'd100);
        chk("t3_idle_valid", {31'd0, if_b.data_valid}, 32'd0);
        chk("t3_idle_vco",   {31'd0, vco_enb_b}, 32'd1);

        // Test 4: back-pressure, overrun, same-edge refill
        if_b.data_ready = 1'b0;
        en_b = 1'b1;
        pv = '0;
        step_b(pv);        // E0
        step_b(pv);        // E1
        for (int n = 2; n <= 15; n++) begin
            s  = (n <= 5) ? 1 : ((n <= 9) ? 2 : 3);
            pv = pv + s[10:0];
            if (n == 13) if_b.data_ready = 1'b1;
            step_b(pv);
            if (n == 5) begin
                chk("t4_valid1",    {31'd0, if_b.data_valid}, 32'd1);
                chk("t4_data1",     {19'd0, if_b.data_out}, 32'd4);
                chk("t4_no_ovr",    {31'd0, overrun_b}, 32'd0);
            end
            if (n == 9) begin
                chk("t4_held_valid", {31'd0, if_b.data_valid}, 32'd1);
                chk("t4_held_data",  {19'd0, if_b.data_out}, 32'd4);
                chk("t4_overrun",    {31'd0, overrun_b}, 32'd1);
            end
            if (n == 12) chk("t4_still_held", {19'd0, if_b.data_out}, 32'd4);
            if (n == 13) begin
                chk("t4_refill_valid", {31'd0, if_b.data_valid}, 32'd1);
                chk("t4_refill_data",  {19'd0, if_b.data_out}, 32'd12);
                chk("t4_ovr_sticky",   {31'd0, overrun_b}, 32'd1);
            end
            if (n == 14) chk("t4_consumed", {31'd0, if_b.data_valid}, 32'd0);
        end

        // Test 5: en dropped two cycles into a block
        en_b = 1'b0;
        step_b(pv);
        chk("t5_vco_enb_off", {31'd0, vco_enb_b}, 32'd1);
        chk("t5_ovr_kept",    {31'd0, overrun_b}, 32'd1);
        step_b(pv);
        chk("t5_no_result",   {31'd0, if_b.data_valid}, 32'd0);
        step_b(pv);
        en_b = 1'b1;
        step_b(11'd500);   // E0'
        chk("t5_ovr_clear",   {31'd0, overrun_b}, 32'd0);
        chk("t5_vco_enb_on",  {31'd0, vco_enb_b}, 32'd0);
        step_b(11'd500);   // E1'
        for (int k = 1; k <= 10; k++) begin
            step_b(11'd500 + 11'(7 * k));
            if (k == 3) chk("t5_valid_early", {31'd0, if_b.data_valid}, 32'd0);
            if (k == 4) begin
                chk("t5_valid", {31'd0, if_b.data_valid}, 32'd1);
                chk("t5_data_fresh", {19'd0, if_b.data_out}, 32'd28);
                if_b.data_ready = 1'b0;
            end
            if (k == 8) chk("t6_pre_ovr", {31'd0, overrun_b}, 32'd1);
        end

        // Test 6: asynchronous reset mid-block with a pending sample
        chk("t6_pre_valid", {31'd0, if_b.data_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid",   {31'd0, if_b.data_valid}, 32'd0);
        chk("t6_rst_data",    {19'd0, if_b.data_out}, 32'd0);
        chk("t6_rst_overrun", {31'd0, overrun_b}, 32'd0);
        chk("t6_rst_vco_enb", {31'd0, vco_enb_b}, 32'd1);
        en_b = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) step_b(11'd9);
        chk("t6_idle_vco",   {31'd0, vco_enb_b}, 32'd1);
        chk("t6_idle_valid", {31'd0, if_b.data_valid}, 32'd0);
        en_b = 1'b1;
        step_b(11'd9);
        chk("t6_restart_vco", {31'd0, vco_enb_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
